// File: rtl/instr_ptr_pkg.sv
// Shared processor constants: instruction-address width agreed by the decoder,
// the instruction pointer and the instruction memory.
package instr_ptr_pkg;

  localparam int unsigned IADDR_W = 8;

endpackage : instr_ptr_pkg

// File: rtl/instr_ptr.sv
// Instruction pointer: synchronous reset, absolute load, or increment by one.
// Priority is reset > load > enable > hold.
module instr_ptr
  import instr_ptr_pkg::*;
#(
  parameter int unsigned       WIDTH     = IADDR_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] ptr_out
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Load overrides increment; the increment wraps silently modulo 2^WIDTH.
  always_comb begin
    ptr_d = ptr_q;
    if (load_enable) begin
      ptr_d = load_val;
    end else if (enable) begin
      ptr_d = WIDTH'(ptr_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= RESET_VAL;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_out = ptr_q;

`ifndef SYNTHESIS
  a_load_visible : assert property (@(posedge clk) disable iff (!rst_n)
    load_enable |=> (ptr_out == $past(load_val)));

  a_incr_by_one : assert property (@(posedge clk) disable iff (!rst_n)
    (enable && !load_enable) |=> (ptr_out == WIDTH'($past(ptr_out) + WIDTH'(1))));
`endif

endmodule : instr_ptr

// File: tb/tb_instr_ptr.sv
// Directed bench for instr_ptr: reset, count, load priority, wrap and mid-run reset.
module tb_instr_ptr;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         load_enable;
  logic [W-1:0] load_val;
  logic [W-1:0] ptr_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  instr_ptr #(
    .WIDTH     (W),
    .RESET_VAL (8'd0)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load_enable (load_enable),
    .load_val    (load_val),
    .ptr_out     (ptr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic [W-1:0] exp);
    step();
    check(tag, ptr_out, exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    load_enable = 1'b1;
    load_val    = 8'd50;

    // Reset wins over load and enable
    step_check("reset", 8'd0);
    rst_n       = 1'b1;
    enable      = 1'b0;
    load_enable = 1'b0;
    step_check("idle0", 8'd0);
    step_check("idle1", 8'd0);

    // Count 1..4 then hold
    enable = 1'b1;
    step_check("cnt1", 8'd1);
    step_check("cnt2", 8'd2);
    step_check("cnt3", 8'd3);
    step_check("cnt4", 8'd4);
    enable = 1'b0;
    step_check("hold4a", 8'd4);
    step_check("hold4b", 8'd4);

    // Load without enable; 500 truncated upstream to 244
    load_enable = 1'b1;
    load_val    = 8'(500);
    step_check("ld244", 8'd244);
    load_enable = 1'b0;
    step_check("ld244_hold", 8'd244);
    load_val    = 'x;
    step_check("x_ignored", 8'd244);

    // Load beats enable; held load tracks load_val without incrementing
    enable      = 1'b1;
    load_enable = 1'b1;
    load_val    = 8'd244;
    step_check("prio244", 8'd244);
    load_val    = 8'(700);
    step_check("prio188a", 8'd188);
    step_check("prio188b", 8'd188);
    step_check("prio188c", 8'd188);
    load_enable = 1'b0;
    load_val    = 8'd7;
    step_check("inc189", 8'd189);
    step_check("inc190", 8'd190);

    // Wrap-around
    load_enable = 1'b1;
    load_val    = 8'd254;
    step_check("wrap254", 8'd254);
    load_enable = 1'b0;
    step_check("wrap255", 8'd255);
    step_check("wrap0", 8'd0);
    step_check("wrap1", 8'd1);

    // Mid-run reset overrides load
    load_enable = 1'b1;
    load_val    = 8'd9;
    step_check("pre9", 8'd9);
    load_enable = 1'b0;
    step_check("pre10", 8'd10);
    rst_n       = 1'b0;
    load_enable = 1'b1;
    load_val    = 8'd50;
    step_check("midrst", 8'd0);
    rst_n       = 1'b1;
    load_enable = 1'b0;
    step_check("postrst1", 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instr_ptr
